arbiter_rr_packet: RTL

- N-input packet-aware round-robin arbiter with valid/ready handshake.
- Shares one DW-wide downstream channel between bus_num requesters. Once a requester wins, the grant is held until its last beat transfers, so packets are never interleaved.
- Sits in front of an arbiter tree or a shared sink where multi-beat transfers must stay contiguous.
- Ends in one registered output stage. It fits in the same flattened-bus valid/ready fabric as the existing arbiter tree.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 36 +++
 rtl/arbiter_rr_packet.sv | 97 +++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg : shared state encoding and sizing helper for round-robin arbiters
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Index width that never collapses to zero for a single requester.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : combinational rotating priority encoder (first req at/after ptr)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  always_comb begin
    dbl    = {req, req};
    masked = '0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    any = |req;
    idx = '0;
    // Downward scan leaves the lowest set position, i.e. the first one from ptr.
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) idx = IW'(i % N);
    end
  end

endmodule

`default_nettype wire

// File: rtl/arbiter_rr_packet.sv
// ----------------------------------------------------------------------------
// arbiter_rr_packet : packet-aware round-robin arbiter, registered output
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module arbiter_rr_packet
  import arb_pkg::*;
#(
  parameter  int bus_num = 8,
  parameter  int DW      = 8,
  localparam int IDW     = clog2_min1(bus_num)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [bus_num-1:0]    valid_in,
  input  logic [bus_num-1:0]    last_in,
  input  logic [bus_num*DW-1:0] data_in,
  output logic [bus_num-1:0]    ready_out,
  output logic                  valid_out,
  output logic                  last_out,
  output logic [DW-1:0]         data_out,
  output logic [IDW-1:0]        grant_id,
  input  logic                  ready_in
);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [IDW-1:0] pick_idx, sel, sel_inc;
  logic           pick_any, sel_ok, can_load, accept;

  rr_pick #(
    .N  (bus_num),
    .IW (IDW)
  ) u_pick (
    .req (valid_in),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign can_load = !valid_out || ready_in;

  always_comb begin
    sel        = (state == LOCK) ? owner : pick_idx;
    sel_ok     = (state == LOCK) || pick_any;
    sel_inc    = (sel == IDW'(bus_num - 1)) ? '0 : sel + 1'b1;
    ready_out  = '0;
    // Held low during reset so no upstream source believes a beat was taken.
    if (sel_ok && can_load && !rst) ready_out[sel] = 1'b1;
    accept     = valid_in[sel] && ready_out[sel];
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    if (accept) begin
      if (last_in[sel]) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = sel_inc;
      end else begin
        state_nxt  = LOCK;
        owner_nxt  = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      data_out  <= '0;
      grant_id  <= '0;
    end else if (accept) begin
      valid_out <= 1'b1;
      last_out  <= last_in[sel];
      data_out  <= data_in[int'(sel) * DW +: DW];
      grant_id  <= sel;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

`default_nettype wire
